// File: rtl/lzc_pkg.sv
// Shared constants and helpers for the pipelined leading-zero counter.
// Provides count-width function and default WIDTH/GROUP values.
package lzc_pkg;

  localparam int LZC_WIDTH_DEF = 32;
  localparam int LZC_GROUP_DEF = 8;

  // Count must represent 0..width inclusive.
  function automatic int lzc_cw(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/lzc_group.sv
// Combinational GROUP-bit priority encoder, MSB-first.
// Ports: d_i group bits; nz_o any bit set; lc_o leading zeros (0 if none set).
module lzc_group
  import lzc_pkg::*;
#(
  parameter int GROUP = LZC_GROUP_DEF,
  localparam int LCW = (GROUP > 1) ? $clog2(GROUP) : 1
) (
  input  logic [GROUP-1:0] d_i,
  output logic             nz_o,
  output logic [LCW-1:0]   lc_o
);

  // Scan LSB to MSB so the highest set bit is the last one to win.
  always_comb begin
    nz_o = |d_i;
    lc_o = '0;
    for (int i = 0; i < GROUP; i++) begin
      if (d_i[i]) lc_o = LCW'(GROUP - 1 - i);
    end
  end

endmodule

// File: rtl/lzc_pipe.sv
// Two-stage pipelined leading-zero counter with valid/ready and tag passthrough.
// Ports: clk, rst (async high); in_valid/in_ready/in_data/in_tag;
// out_valid/out_ready/out_count/out_zero/out_tag; out_norm with LZC_NORM_EN.
module lzc_pipe
  import lzc_pkg::*;
#(
  parameter int WIDTH = LZC_WIDTH_DEF,
  parameter int GROUP = LZC_GROUP_DEF,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [lzc_cw(WIDTH)-1:0] out_count,
  output logic                     out_zero,
  output logic [TAG_W-1:0]         out_tag
`ifdef LZC_NORM_EN
  ,
  output logic [WIDTH-1:0]         out_norm
`endif
);

  localparam int CW  = lzc_cw(WIDTH);
  localparam int NG  = WIDTH / GROUP;
  localparam int LCW = (GROUP > 1) ? $clog2(GROUP) : 1;

  logic             s1_valid_q;
  logic             s2_valid_q;
  logic             en1;
  logic             en2;

  logic [NG-1:0]    nz_w;
  logic [LCW-1:0]   lc_w [NG];
  logic [NG-1:0]    v_q;
  logic [LCW-1:0]   lc_q [NG];
  logic [TAG_W-1:0] tag1_q;

  logic [CW-1:0]    cnt_d;
  logic [CW-1:0]    cnt_q;
  logic             zero_d;
  logic             zero_q;
  logic [TAG_W-1:0] tag2_q;

`ifdef LZC_NORM_EN
  logic [WIDTH-1:0] data1_q;
  logic [WIDTH-1:0] norm_d;
  logic [WIDTH-1:0] norm_q;
`endif

  assign en2      = !s2_valid_q || out_ready;
  assign en1      = !s1_valid_q || en2;
  assign in_ready = en1;

  // Group 0 is the most significant group.
  for (genvar g = 0; g < NG; g++) begin : g_grp
    lzc_group #(.GROUP(GROUP)) u_grp (
      .d_i  (in_data[WIDTH-1-g*GROUP -: GROUP]),
      .nz_o (nz_w[g]),
      .lc_o (lc_w[g])
    );
  end

  // Payload loads only on real beats, so X data on bubbles never propagates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      v_q        <= '0;
      tag1_q     <= '0;
      for (int g = 0; g < NG; g++) lc_q[g] <= '0;
`ifdef LZC_NORM_EN
      data1_q    <= '0;
`endif
    end else if (en1) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        v_q    <= nz_w;
        tag1_q <= in_tag;
        for (int g = 0; g < NG; g++) lc_q[g] <= lc_w[g];
`ifdef LZC_NORM_EN
        data1_q <= in_data;
`endif
      end
    end
  end

  // Lowest-index nonzero group wins; scanning downward lets it overwrite.
  always_comb begin
    cnt_d  = CW'(WIDTH);
    zero_d = 1'b1;
    for (int g = NG - 1; g >= 0; g--) begin
      if (v_q[g]) begin
        cnt_d  = CW'(g * GROUP) + CW'(lc_q[g]);
        zero_d = 1'b0;
      end
    end
  end

`ifdef LZC_NORM_EN
  always_comb begin
    norm_d = '0;
    if (!zero_d) norm_d = data1_q << cnt_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      cnt_q      <= '0;
      zero_q     <= 1'b0;
      tag2_q     <= '0;
`ifdef LZC_NORM_EN
      norm_q     <= '0;
`endif
    end else if (en2) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        cnt_q  <= cnt_d;
        zero_q <= zero_d;
        tag2_q <= tag1_q;
`ifdef LZC_NORM_EN
        norm_q <= norm_d;
`endif
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_count = cnt_q;
  assign out_zero  = zero_q;
  assign out_tag   = tag2_q;
`ifdef LZC_NORM_EN
  assign out_norm  = norm_q;
`endif

endmodule
